// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bits needed to hold WIDTH-1; never less than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bits-remaining down-counter: loads WIDTH-1, decrements on enable, flags zero.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] r_cnt;

  // Clear wins over load, load wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(WIDTH - 1);
    end else if (i_dec) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_shift_reg_ctrl.sv
// Parallel-in/serial-out shift register with load handshake and framing flags.
// Handshake: a word transfers on a rising edge where load_valid && load_ready && !abort; the source holds din_par/load_valid until then.
module piso_shift_reg_ctrl
  import piso_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_par,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

  piso_state_t      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic             w_zero;
  logic             w_in_shift;
  logic             w_accept;
  logic             w_shift;

  assign w_in_shift = (r_state == SHIFT);
  assign load_ready = !w_in_shift || (w_zero && shift_en);
  assign w_accept   = load_valid && load_ready && !abort;
  assign w_shift    = w_in_shift && shift_en && !w_zero && !abort;

  always_comb begin
    if (MSB_FIRST) w_shifted = {r_shreg[WIDTH-2:0], FILL_BIT};
    else           w_shifted = {FILL_BIT, r_shreg[WIDTH-1:1]};
  end

  // On the last bit, an accept reloads directly so the next word follows with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shreg <= din_par;
    end else if (w_shift) begin
      r_shreg <= w_shifted;
    end else if (w_in_shift && w_zero && shift_en) begin
      r_state <= IDLE;
    end
  end

  piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (abort),
    .i_load (w_accept),
    .i_dec  (w_shift),
    .o_zero (w_zero)
  );

  assign dout       = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign dout_valid = w_in_shift;
  assign dout_last  = w_in_shift && w_zero;
  assign busy       = w_in_shift;

endmodule

// File: tb/tb_piso_shift_reg_ctrl.sv
// Bench for piso_shift_reg_ctrl: bit-queue reference model, per-cycle compare, directed literal checks.
module tb_piso_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din_par = '0;
  logic       load_valid = 1'b0;
  logic       shift_en = 1'b0;
  logic       abort = 1'b0;

  logic rdy_m, dout_m, v_m, last_m, busy_m;
  logic rdy_l, dout_l, v_l, last_l, busy_l;

  int total = 0;
  int bad = 0;

  // Expected bit streams, front element = bit currently on dout.
  logic exp_q[$];
  logic exp_lq[$];

  // Logs of valid bits seen on dout, newest in bit 0.
  logic [31:0] log_d, log_l, log_r, log_dl;
  int          log_n;
  logic [3:0]  sipo = '0;

  always #5 clk = ~clk;

  piso_shift_reg_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .din_par(din_par), .load_valid(load_valid),
    .load_ready(rdy_m), .shift_en(shift_en), .abort(abort), .dout(dout_m),
    .dout_valid(v_m), .dout_last(last_m), .busy(busy_m)
  );

  piso_shift_reg_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0), .FILL_BIT(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .din_par(din_par), .load_valid(load_valid),
    .load_ready(rdy_l), .shift_en(shift_en), .abort(abort), .dout(dout_l),
    .dout_valid(v_l), .dout_last(last_l), .busy(busy_l)
  );

  // Loopback receiver: captures every valid bit of the MSB-first stream.
  always @(posedge clk) if (v_m) sipo <= {sipo[2:0], dout_m};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes WIDTH queued bits; each enabled cycle consumes one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_lq.delete();
    end else if (abort) begin
      exp_q.delete();
      exp_lq.delete();
    end else begin
      logic rdy;
      rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && shift_en);
      if (exp_q.size() > 0 && shift_en) begin
        void'(exp_q.pop_front());
        void'(exp_lq.pop_front());
      end
      if (load_valid && rdy) begin
        for (int i = 3; i >= 0; i--) exp_q.push_back(din_par[i]);
        for (int i = 0; i <= 3; i++) exp_lq.push_back(din_par[i]);
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial begin
    forever begin
      logic ev, el, er;
      @(negedge clk);
      ev = (exp_q.size() != 0);
      el = (exp_q.size() == 1);
      er = (exp_q.size() == 0) || (exp_q.size() == 1 && shift_en);
      check("valid_m", 32'(v_m), 32'(ev));
      check("last_m", 32'(last_m), 32'(el));
      check("busy_m", 32'(busy_m), 32'(ev));
      check("ready_m", 32'(rdy_m), 32'(er));
      check("valid_l", 32'(v_l), 32'(ev));
      check("last_l", 32'(last_l), 32'(el));
      check("ready_l", 32'(rdy_l), 32'(er));
      if (ev) begin
        check("dout_m", 32'(dout_m), 32'(exp_q[0]));
        check("dout_l", 32'(dout_l), 32'(exp_lq[0]));
      end
      if (v_m) begin
        log_d  = {log_d[30:0], dout_m};
        log_l  = {log_l[30:0], last_m};
        log_r  = {log_r[30:0], rdy_m};
        log_dl = {log_dl[30:0], dout_l};
        log_n++;
      end
    end
  end

  task automatic clr_log();
    log_d = '0; log_l = '0; log_r = '0; log_dl = '0; log_n = 0;
  endtask

  // Inputs change 1 time unit after a rising edge and are held for one cycle.
  task automatic cyc(input logic lv, input logic [3:0] d, input logic se, input logic ab);
    load_valid = lv; din_par = d; shift_en = se; abort = ab;
    @(posedge clk); #1;
  endtask

  initial begin
    clr_log();
    #2;
    check("rst_ready", 32'(rdy_m), 32'd1);
    check("rst_valid", 32'(v_m), 32'd0);
    check("rst_dout", 32'(dout_m), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, MSB first, plus loopback receiver.
    clr_log();
    cyc(1, 4'b1011, 1, 0);
    repeat (4) cyc(0, 4'h0, 1, 0);
    check("t1_count", 32'(log_n), 32'd4);
    check("t1_bits", log_d[3:0], 32'b1011);
    check("t1_last", log_l[3:0], 32'b0001);
    check("t1_sipo", 32'(sipo), 32'b1011);
    cyc(0, 4'h0, 1, 0);

    // Back-to-back words stream without a gap.
    clr_log();
    cyc(1, 4'hA, 1, 0);
    repeat (3) cyc(0, 4'h0, 1, 0);
    cyc(1, 4'h5, 1, 0);
    repeat (4) cyc(0, 4'h0, 1, 0);
    check("t2_count", 32'(log_n), 32'd8);
    check("t2_bits", log_d[7:0], 32'b1010_0101);
    check("t2_ready", log_r[7:0], 32'b0001_0001);
    check("t2_last", log_l[7:0], 32'b0001_0001);
    cyc(0, 4'h0, 1, 0);

    // Stall after bit 2 with a word offered during the stall.
    clr_log();
    cyc(1, 4'b1100, 1, 0);
    cyc(0, 4'h0, 1, 0);
    repeat (3) cyc(1, 4'h7, 0, 0);
    cyc(0, 4'h0, 1, 0);
    repeat (2) cyc(0, 4'h0, 1, 0);
    check("t3_count", 32'(log_n), 32'd7);
    check("t3_bits", log_d[6:0], 32'b1111100);
    check("t3_last", log_l[6:0], 32'b0000001);
    repeat (2) cyc(0, 4'h0, 1, 0);
    check("t3_no_accept", 32'(log_n), 32'd7);

    // LSB-first instance.
    clr_log();
    cyc(1, 4'b0001, 1, 0);
    repeat (5) cyc(0, 4'h0, 1, 0);
    check("t4_lsb_bits", log_dl[3:0], 32'b1000);

    // Abort on bit 2 drops both the word and the concurrent load.
    clr_log();
    cyc(1, 4'hF, 1, 0);
    cyc(0, 4'h0, 1, 0);
    cyc(1, 4'h3, 1, 1);
    cyc(0, 4'h3, 1, 0);
    check("t5_abort_valid", 32'(v_m), 32'd0);
    check("t5_abort_count", 32'(log_n), 32'd2);
    clr_log();
    cyc(1, 4'h3, 1, 0);
    repeat (5) cyc(0, 4'h0, 1, 0);
    check("t5_retry_count", 32'(log_n), 32'd4);
    check("t5_retry_bits", log_d[3:0], 32'b0011);

    // Asynchronous reset mid-word.
    cyc(1, 4'hA, 1, 0);
    check("t6_pre_valid", 32'(v_m), 32'd1);
    check("t6_pre_dout", 32'(dout_m), 32'd1);
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_dout", 32'(dout_m), 32'd0);
    check("t6_valid", 32'(v_m), 32'd0);
    check("t6_last", 32'(last_m), 32'd0);
    check("t6_busy", 32'(busy_m), 32'd0);
    check("t6_busy_l", 32'(busy_l), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_ready", 32'(rdy_m), 32'd1);

    // Randomized traffic against the model.
    repeat (600) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 24) == 0));
    end
    repeat (6) cyc(0, 4'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_shift_reg_ctrl.md
Name: piso_shift_reg_ctrl

Overview:
Parameterised parallel-in/serial-out shift register with a load handshake and bit-framing outputs. It is the transmit end of the 4-bit SIPO shift register. A parallel word is accepted, then driven out one bit per enabled clock, MSB first by default. When `dout` drives the SIPO's `din` on a shared clock, the SIPO's `q` equals the sent word once the last bit has been captured. Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 4: word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- FILL_BIT, 1'b0: value shifted into the vacated end of the register.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- din_par  in  WIDTH  parallel word to serialise.
- load_valid  in  1  din_par holds a valid word.
- load_ready  out  1  the block can accept a word this cycle.
- shift_en  in  1  advance one bit this cycle; when low, serial output stalls.
- abort  in  1  synchronous flush of the word in flight.
- dout  out  1  serial data.
- dout_valid  out  1  dout carries a valid bit.
- dout_last  out  1  dout is the final bit of the word.
- busy  out  1  a word is in flight; equals dout_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; shreg = 0; cnt = 0.
  - dout = 0, dout_valid = 0, dout_last = 0, busy = 0.
  - load_ready = 1 while in reset and afterwards, because it is decoded from registered state.
- States:
  - IDLE: no word held.
  - SHIFT: a word is being sent; cnt = number of bits remaining after the current one.
- Output decode, from registers only (no input-to-output combinational paths except load_ready):
  - dout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - dout_valid = (state == SHIFT).
  - dout_last = (state == SHIFT) && (cnt == 0).
- load_ready = (state == IDLE) || (state == SHIFT && cnt == 0 && shift_en) — combinational from state, cnt and shift_en.
- Accept: a rising edge with load_valid && load_ready does all of the following:
  - shreg <= din_par; cnt <= WIDTH-1; state <= SHIFT.
  - Latency: a word accepted at edge k puts its first bit on dout during the cycle after edge k.
- Shift: in SHIFT with shift_en=1 and cnt > 0:
  - shreg shifts toward the output end, with FILL_BIT entering the vacated end.
  - cnt decrements by 1.
- Stall: in SHIFT with shift_en=0, shreg, cnt, dout and dout_last hold; a word presented on load_valid is not accepted.
- Last bit: in SHIFT with cnt == 0 and shift_en=1:
  - If load_valid: reload as in Accept, so the next word's first bit follows with no gap and dout_valid stays 1.
  - Otherwise: state <= IDLE.
- Abort:
  - Highest priority after reset: state <= IDLE, cnt <= 0, shreg <= 0.
  - A load presented in the same cycle is dropped; it is not accepted even though load_ready may read 1.
  - abort in IDLE has no effect.
- Bit count: exactly WIDTH shift_en-qualified cycles per word, including the last-bit cycle. cnt width is $clog2(WIDTH).
- Reset mid-word: outputs drop immediately (asynchronously); the partial word is lost.
- load_valid with load_ready=0: no effect; the source must hold din_par and load_valid until accepted.
- din_par changes while not loading: ignored.

Decomposition:
- Package piso_pkg holds:
  - the typedef enum logic {IDLE, SHIFT} piso_state_t;
  - the localparam functions for counter width;
  - the default WIDTH.
- One natural sub-module, piso_bit_cnt:
  - load-to-WIDTH-1 down-counter with enable;
  - outputs zero-flag.
  - Everything else stays in the top level.

Test Plan:
- Reset release, WIDTH=4, MSB_FIRST=1, shift_en=1, load 4'b1011 → dout = 1,0,1,1 on the four cycles after the accept edge. dout_last is high only on the 4th bit. A SIPO in loopback shows q = 4'b1011 at the following edge.
- Back-to-back: load 4'hA, hold load_valid with 4'h5 during the last bit → 8 contiguous valid bits 1,0,1,0,0,1,0,1. dout_valid never drops; load_ready pulses on bit 4.
- Stall: load 4'b1100, drop shift_en for 3 cycles after bit 2 → dout holds 1 and dout_last holds 0 through the stall. Sequence resumes 0,0, total 4 enabled bits; load_valid during the stall is not accepted.
- MSB_FIRST=0, load 4'b0001 → dout = 1,0,0,0.
- Abort on bit 2 of 4'hF with load_valid=1 and din_par=4'h3 → next cycle state is IDLE, dout_valid=0, and 4'h3 is not accepted. Re-presenting 4'h3 later yields 0,0,1,1.
- Assert rst_n=0 asynchronously mid-word → dout, dout_valid, dout_last and busy go to 0 before the next clock edge. load_ready=1 after release.
